// File: rtl/hd44780_lcd_responder.sv
// Display-side HD44780 model: synchronizes the RS/E/D bus, assembles bytes, runs the instruction subset, holds DDRAM.
// Optional build macro HD44780_TIMING_CHECK_EN adds busy-strobe and strobe-cadence violation checks.
module hd44780_lcd_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int CMD_BUSY    = 40,
    parameter int CLR_BUSY    = 1640
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RS,
    input  logic       E,
    input  logic [3:0] D,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       byte_vld,
    output logic       byte_rs,
    output logic [7:0] byte_dat,
    output logic [6:0] ac,
    output logic       mode4,
    output logic       disp_on,
    output logic       inc_mode,
    output logic       two_line,
    output logic       busy,
    output logic       viol
);
    localparam int BMAX = (CLR_BUSY > CMD_BUSY) ? CLR_BUSY : CMD_BUSY;
    localparam int BW   = $clog2(BMAX + 1);
    localparam logic [BW-1:0] B_ONE = 1;

    typedef enum logic [1:0] {MODE8, NIB_HI, NIB_LO} state_t;

    logic [SYNC_STAGES-1:0]       rs_sync_q, e_sync_q;
    logic [SYNC_STAGES-1:0][3:0]  d_sync_q;
    logic                         e_last_q, rs_cap_q;
    logic [3:0]                   d_cap_q;
    logic                         e_s, strobe;

    state_t     state_q, state_d;
    logic [3:0] hi_q, hi_d;
    logic       rs_hi_q, rs_hi_d;
    logic [7:0] mem_q [80];
    logic [7:0] mem_d [80];
    logic [6:0] ac_q, ac_d;
    logic       mode4_q, mode4_d, disp_q, disp_d, inc_q, inc_d, two_q, two_d;
    logic       vld_q, vld_d, brs_q, brs_d, viol_q, viol_d;
    logic [7:0] bdat_q, bdat_d;
    logic [BW-1:0] busy_q, busy_d;
    logic       exec, x_rs;
    logic [7:0] x_byte;

    function automatic logic map_ok(input logic [6:0] a);
        return (a < 7'h28) || (a >= 7'h40 && a < 7'h68);
    endfunction

    // Line 2 (0x40..0x67) packs right after line 1's 40 bytes.
    function automatic logic [6:0] map_idx(input logic [6:0] a);
        return (a < 7'h40) ? a : a - 7'd24;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else     return (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
    endfunction

    assign e_s    = e_sync_q[SYNC_STAGES-1];
    assign strobe = e_last_q & ~e_s;

`ifdef HD44780_TIMING_CHECK_EN
    logic [2:0] spc_q, spc_d;
    always_comb begin
        spc_d = spc_q;
        if (strobe)             spc_d = 3'd1;
        else if (spc_q < 3'd4)  spc_d = spc_q + 3'd1;
    end
`endif

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        rs_hi_d = rs_hi_q;
        mem_d   = mem_q;
        ac_d    = ac_q;
        mode4_d = mode4_q;
        disp_d  = disp_q;
        inc_d   = inc_q;
        two_d   = two_q;
        vld_d   = 1'b0;
        brs_d   = brs_q;
        bdat_d  = bdat_q;
        viol_d  = viol_q;
        busy_d  = (busy_q != '0) ? busy_q - B_ONE : busy_q;
        exec    = 1'b0;
        x_rs    = rs_cap_q;
        x_byte  = {d_cap_q, 4'h0};

        if (strobe) begin
            case (state_q)
                MODE8: exec = 1'b1;
                NIB_HI: begin
                    hi_d    = d_cap_q;
                    rs_hi_d = rs_cap_q;
                    state_d = NIB_LO;
                end
                default: begin
                    exec    = 1'b1;
                    x_rs    = rs_hi_q;
                    x_byte  = {hi_q, d_cap_q};
                    state_d = NIB_HI;
                    if (rs_cap_q != rs_hi_q) viol_d = 1'b1;
                end
            endcase
`ifdef HD44780_TIMING_CHECK_EN
            if (busy_q != '0 || spc_q < 3'd4) viol_d = 1'b1;
`endif
        end

        if (exec) begin
            vld_d  = 1'b1;
            brs_d  = x_rs;
            bdat_d = x_byte;
            busy_d = BW'(CMD_BUSY);
            if (x_rs) begin
                if (map_ok(ac_q)) mem_d[map_idx(ac_q)] = x_byte;
                ac_d = ac_step(ac_q, inc_q);
            end else begin
                casez (x_byte)
                    8'b1???????: ac_d = x_byte[6:0];
                    8'b01??????: ;
                    8'b001?????: begin
                        two_d = x_byte[3];
                        if (x_byte[4]) begin
                            state_d = MODE8;
                            mode4_d = 1'b0;
                        end else begin
                            state_d = NIB_HI;
                            mode4_d = 1'b1;
                        end
                    end
                    8'b0001????: ;
                    8'b00001???: disp_d = x_byte[2];
                    8'b000001??: inc_d  = x_byte[1];
                    8'b0000001?: begin
                        ac_d   = 7'h00;
                        busy_d = BW'(CLR_BUSY);
                    end
                    8'b00000001: begin
                        for (int i = 0; i < 80; i++) mem_d[i] = 8'h20;
                        ac_d   = 7'h00;
                        inc_d  = 1'b1;
                        busy_d = BW'(CLR_BUSY);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            rs_sync_q <= '0;
            e_sync_q  <= '0;
            d_sync_q  <= '0;
            e_last_q  <= 1'b0;
            rs_cap_q  <= 1'b0;
            d_cap_q   <= 4'h0;
            state_q   <= MODE8;
            hi_q      <= 4'h0;
            rs_hi_q   <= 1'b0;
            for (int i = 0; i < 80; i++) mem_q[i] <= 8'h20;
            ac_q      <= 7'h00;
            mode4_q   <= 1'b0;
            disp_q    <= 1'b0;
            inc_q     <= 1'b1;
            two_q     <= 1'b0;
            vld_q     <= 1'b0;
            brs_q     <= 1'b0;
            bdat_q    <= 8'h00;
            viol_q    <= 1'b0;
            busy_q    <= '0;
        end else begin
            rs_sync_q <= {rs_sync_q[SYNC_STAGES-2:0], RS};
            e_sync_q  <= {e_sync_q[SYNC_STAGES-2:0], E};
            d_sync_q  <= {d_sync_q[SYNC_STAGES-2:0], D};
            e_last_q  <= e_s;
            // Hold RS/D from the last cycle E was high; the strobe cycle uses these.
            if (e_s) begin
                rs_cap_q <= rs_sync_q[SYNC_STAGES-1];
                d_cap_q  <= d_sync_q[SYNC_STAGES-1];
            end
            state_q   <= state_d;
            hi_q      <= hi_d;
            rs_hi_q   <= rs_hi_d;
            mem_q     <= mem_d;
            ac_q      <= ac_d;
            mode4_q   <= mode4_d;
            disp_q    <= disp_d;
            inc_q     <= inc_d;
            two_q     <= two_d;
            vld_q     <= vld_d;
            brs_q     <= brs_d;
            bdat_q    <= bdat_d;
            viol_q    <= viol_d;
            busy_q    <= busy_d;
        end
    end

`ifdef HD44780_TIMING_CHECK_EN
    // Starts saturated so the first strobe after reset is never a cadence violation.
    always_ff @(posedge CLK) begin
        if (!RST) spc_q <= 3'd4;
        else      spc_q <= spc_d;
    end
`endif

    assign rd_data  = map_ok(rd_addr) ? mem_q[map_idx(rd_addr)] : 8'h20;
    assign byte_vld = vld_q;
    assign byte_rs  = brs_q;
    assign byte_dat = bdat_q;
    assign ac       = ac_q;
    assign mode4    = mode4_q;
    assign disp_on  = disp_q;
    assign inc_mode = inc_q;
    assign two_line = two_q;
    assign busy     = (busy_q != '0);
    assign viol     = viol_q;
endmodule

// File: tb/tb_hd44780_lcd_responder.sv
// Directed bench for hd44780_lcd_responder: init, writes, ac wrap, clear timing, violation flags.
module tb_hd44780_lcd_responder;
    localparam int CMDB = 10;
    localparam int CLRB = 60;
    localparam int GAP  = 80;

    logic       CLK = 1'b0, RST = 1'b0, RS = 1'b0, E = 1'b0;
    logic [3:0] D = 4'h0;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] rd_data, byte_dat;
    logic [6:0] ac;
    logic       byte_vld, byte_rs, mode4, disp_on, inc_mode, two_line, busy, viol;

    int n_tests = 0, n_fail = 0;
    int vld_rs_cnt = 0;
    logic [7:0] last_dat = 8'h00;

    hd44780_lcd_responder #(.SYNC_STAGES(2), .CMD_BUSY(CMDB), .CLR_BUSY(CLRB)) dut (
        .CLK(CLK), .RST(RST), .RS(RS), .E(E), .D(D), .rd_addr(rd_addr), .rd_data(rd_data),
        .byte_vld(byte_vld), .byte_rs(byte_rs), .byte_dat(byte_dat), .ac(ac), .mode4(mode4),
        .disp_on(disp_on), .inc_mode(inc_mode), .two_line(two_line), .busy(busy), .viol(viol)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (byte_vld && byte_rs) vld_rs_cnt <= vld_rs_cnt + 1;
        if (byte_vld) last_dat <= byte_dat;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nib(input logic rs, input logic [3:0] d, input int gap);
        @(negedge CLK);
        RS = rs; D = d; E = 1'b1;
        repeat (4) @(negedge CLK);
        E = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic byte4(input logic rs, input logic [7:0] b);
        nib(rs, b[7:4], GAP);
        nib(rs, b[3:0], GAP);
    endtask

    task automatic rd(input logic [6:0] a, input logic [7:0] exp, input string tag);
        rd_addr = a;
        #1;
        chk(tag, rd_data, exp);
    endtask

    int n, cnt, snap;
    logic expv;

    initial begin
        // 1 reset
        repeat (3) @(negedge CLK);
        chk("rst_ac", ac, 0);
        chk("rst_mode4", mode4, 0);
        chk("rst_inc", inc_mode, 1);
        chk("rst_viol", viol, 0);
        chk("rst_busy", busy, 0);
        rd(7'h00, 8'h20, "rst_rd0");
        RST = 1'b1;

        // 2 init in 8-bit mode, then switch to 4-bit
        nib(0, 4'h3, GAP); nib(0, 4'h3, GAP); nib(0, 4'h3, GAP);
        chk("init_mode4_pre", mode4, 0);
        nib(0, 4'h2, GAP);
        chk("init_mode4", mode4, 1);
        byte4(0, 8'h28);
        chk("init_two_line", two_line, 1);
        byte4(0, 8'h0C);
        chk("init_disp_on", disp_on, 1);
        chk("init_ac", ac, 0);

        // 3 data writes
        snap = vld_rs_cnt;
        byte4(1, 8'h54);
        byte4(1, 8'h68);
        rd(7'h00, 8'h54, "wr_rd0");
        rd(7'h01, 8'h68, "wr_rd1");
        chk("wr_ac", ac, 7'h02);
        chk("wr_vld_cnt", vld_rs_cnt - snap, 2);
        chk("wr_last_dat", last_dat, 8'h68);
        rd(7'h30, 8'h20, "unmapped_rd");

        // 4 ac wrap, increment then decrement
        byte4(0, 8'hA7);
        chk("wrap_set_ac", ac, 7'h27);
        byte4(1, 8'h41);
        rd(7'h27, 8'h41, "wrap_rd27");
        chk("wrap_ac_inc", ac, 7'h40);
        byte4(0, 8'h04);
        chk("wrap_inc_mode", inc_mode, 0);
        byte4(0, 8'h80);
        byte4(1, 8'h42);
        rd(7'h00, 8'h42, "wrap_rd0");
        chk("wrap_ac_dec", ac, 7'h67);

        // 5 clear display and busy length
        nib(0, 4'h0, GAP);
        nib(0, 4'h1, 0);
        n = 0;
        while (!busy && n < 20) begin @(negedge CLK); n++; end
        chk("clr_busy_rise", busy, 1);
        cnt = 0;
        while (busy && cnt < 1000) begin cnt++; @(negedge CLK); end
        chk("clr_busy_len", cnt, CLRB);
        cnt = 0;
        for (int a = 0; a < 128; a++) begin
            rd_addr = a[6:0];
            #1;
            if (rd_data !== 8'h20) cnt++;
        end
        chk("clr_ddram_blank", cnt, 0);
        chk("clr_ac", ac, 0);
        chk("clr_inc_mode", inc_mode, 1);
        repeat (GAP) @(negedge CLK);

        // 6 strobe while busy from a clear
        nib(0, 4'h0, GAP);
        nib(0, 4'h1, 7);
        nib(0, 4'h0, 10);
`ifdef HD44780_TIMING_CHECK_EN
        expv = 1'b1;
`else
        expv = 1'b0;
`endif
        chk("busy_strobe_viol", viol, expv);
        repeat (GAP) @(negedge CLK);
        nib(0, 4'h0, GAP);
        chk("busy_viol_sticky", viol, expv);

        // RS mismatch between nibble halves
        nib(0, 4'h0, GAP);
        nib(1, 4'hC, GAP);
        chk("rs_mismatch_viol", viol, 1);

        // reset clears sticky flag and mode
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst2_viol", viol, 0);
        chk("rst2_mode4", mode4, 0);
        chk("rst2_disp_on", disp_on, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
